hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255, maximum MEM_WAIT cycles before fault.
REQ-002 clk  input  1  single core clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rsD, rtD  input  5 each  source registers of the instruction in Decode.
REQ-005 rsE, rtE  input  5 each  source registers of the instruction in Execute.
REQ-006 writeregE, writeregM, writeregW  input  5 each  destination registers in E/M/W.
REQ-007 regwriteE, regwriteM, regwriteW  input  1 each  register write-enables in E/M/W.
REQ-008 memtoregE, memtoregM  input  1 each  load-in-stage flags.
REQ-009 branchD  input  1  branch in Decode; pcsrcD  input  1  branch taken (redirect pc).
REQ-010 memreqM  input  1  data-memory access in M; memackM  input  1  data-memory done this cycle.
REQ-011 stallcnt_clr  input  1  synchronous clear of stall counter.
REQ-012 forwardAE, forwardBE  output  2 each  EX operand select: 00 register file, 01 resultW, 10 aluoutM.
REQ-013 forwardAD, forwardBD  output  1 each  Decode comparator bypass from aluoutM.
REQ-014 stallF, stallD, stallE, stallM  output  1 each  hold pipeline register.
REQ-015 flushD, flushE, flushW  output  1 each  insert bubble into D/E/W register.
REQ-016 fault  output  1  sticky memory-timeout error; stallcnt  output  16  stall-cycle count.

Function
REQ-017 forwardAE SHALL be 10 when rsE!=0 && regwriteM && rsE==writeregM; else 01 when rsE!=0 && regwriteW && rsE==writeregW; else 00 (M beats W); forwardBE identically on rtE.
REQ-018 forwardAD SHALL be rsD!=0 && regwriteM && rsD==writeregM; forwardBD identically on rtD.
REQ-019 lwstall SHALL be memtoregE && rtE!=0 && (rtE==rsD || rtE==rtD).
REQ-020 brstall SHALL be branchD && ((regwriteE && writeregE!=0 && writeregE in {rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM in {rsD,rtD})).
REQ-021 FSM states RUN, MEM_WAIT, FAULT: RUN->MEM_WAIT on memreqM && !memackM; MEM_WAIT->RUN on memackM; MEM_WAIT->FAULT when waitcnt==MEM_TIMEOUT && !memackM; FAULT exits only by reset.
REQ-022 waitcnt (8 bit) SHALL load 1 on RUN->MEM_WAIT, increment each MEM_WAIT cycle, and not wrap.
REQ-023 memstall SHALL be memreqM && !memackM in RUN or MEM_WAIT, and 1 in FAULT.
REQ-024 stallF=stallD SHALL be lwstall|brstall|memstall; stallE=stallM=memstall; flushW=memstall.
REQ-025 flushE SHALL be (lwstall|brstall) && !memstall; memstall takes priority, E is frozen, not flushed.
REQ-026 flushD SHALL be pcsrcD && !stallD; a taken branch during any stall is deferred.
REQ-027 Memack in the same cycle as memreqM SHALL cause no stall and no state change.
REQ-028 fault SHALL be 1 exactly when state==FAULT.
REQ-029 stallcnt SHALL increment each cycle stallF==1, saturate at 16'hFFFF, and load 0 on stallcnt_clr (clear wins over increment).
REQ-030 All outputs except fault and stallcnt SHALL be combinational in inputs and state; zero-cycle latency.

Reset
REQ-031 reset SHALL immediately force state=RUN, waitcnt=0, stallcnt=0, fault=0, independent of clk.
REQ-032 Reset during MEM_WAIT or FAULT SHALL abandon the wait; the next cycle starts in RUN.

Structure
REQ-033 Shared package core_pkg SHALL hold fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and hz_state_t (RUN, MEM_WAIT, FAULT).
REQ-034 Per-operand forwarding compare SHALL be sub-module fwd_sel, instantiated twice (A, B).

Verification
REQ-035 rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardAE=10; with regwriteM=0 -> 01; with rsE=0 -> 00.
REQ-036 memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1, stallE=0, stallcnt +1 next cycle.
REQ-037 branchD=1, regwriteE=1, writeregE=4, rtD=4, pcsrcD=1 -> stallD=1, flushE=1, flushD=0.
REQ-038 memreqM=1, memackM=0 for 3 cycles then 1 -> MEM_WAIT for 3 cycles, stallE=stallM=flushW=1, flushE=0, back to RUN.
REQ-039 MEM_TIMEOUT=4, memackM held 0 -> fault=1 after waitcnt reaches 4, all stalls stay 1; assert reset mid-FAULT -> fault=0 at once.
REQ-040 stallcnt preloaded to FFFF by held stall -> stays FFFF; stallcnt_clr=1 with stallF=1 -> 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared hazard-unit types: forwarding selects, hazard FSM states and a register-match helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_pkg;

   // EX operand mux select; encodings match the datapath mux ordering.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FAULT    = 2'b10
   } hz_state_t;

   // True when src names a real register (r0 is hardwired zero) equal to dst.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding compare: EX operand select and Decode comparator bypass.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of current pipeline register contents.
// Ports: srce/srcd = operand source register in E/D; writeregm/w + regwritem/w = producers in M/W;
//        fwde = EX mux select (M beats W); fwdd = Decode bypass from aluoutM.
import core_pkg::*;

module fwd_sel (
   input  logic [4:0] srce,
   input  logic [4:0] srcd,
   input  logic [4:0] writeregm,
   input  logic       regwritem,
   input  logic [4:0] writeregw,
   input  logic       regwritew,
   output fwd_sel_t   fwde,
   output logic       fwdd
);

   // M holds the younger result, so it must win over W.
   always_comb begin
      fwde = FWD_RF;
      if (regwritem && reg_match(srce, writeregm))
         fwde = FWD_MEM;
      else if (regwritew && reg_match(srce, writeregw))
         fwde = FWD_WB;
   end

   assign fwdd = regwritem && reg_match(srcd, writeregm);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use/branch/memory stalls, flushes, timeout fault.
// Latency: stall/flush/forward outputs combinational (zero cycles); fault and stallcnt registered.
// Backpressure: an outstanding data-memory access freezes F..M and bubbles W until memackM.
// Ports: rs/rt/writereg/regwrite/memtoreg per stage in; branchD/pcsrcD in; memreqM/memackM in;
//        stallcnt_clr in; forward*, stall*, flush*, fault, stallcnt out.
import core_pkg::*;

module hazard_ctrl #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [4:0]  rsE,
   input  logic [4:0]  rtE,
   input  logic [4:0]  writeregE,
   input  logic [4:0]  writeregM,
   input  logic [4:0]  writeregW,
   input  logic        regwriteE,
   input  logic        regwriteM,
   input  logic        regwriteW,
   input  logic        memtoregE,
   input  logic        memtoregM,
   input  logic        branchD,
   input  logic        pcsrcD,
   input  logic        memreqM,
   input  logic        memackM,
   input  logic        stallcnt_clr,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        forwardAD,
   output logic        forwardBD,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        flushD,
   output logic        flushE,
   output logic        flushW,
   output logic        fault,
   output logic [15:0] stallcnt
);

   hz_state_t  state;
   logic [7:0] waitcnt;
   fwd_sel_t   fwda_e;
   fwd_sel_t   fwdb_e;
   logic       lwstall;
   logic       brstall;
   logic       memstall;
   logic       mem_pending;

   fwd_sel u_fwd_a (
      .srce      (rsE),
      .srcd      (rsD),
      .writeregm (writeregM),
      .regwritem (regwriteM),
      .writeregw (writeregW),
      .regwritew (regwriteW),
      .fwde      (fwda_e),
      .fwdd      (forwardAD)
   );

   fwd_sel u_fwd_b (
      .srce      (rtE),
      .srcd      (rtD),
      .writeregm (writeregM),
      .regwritem (regwriteM),
      .writeregw (writeregW),
      .regwritew (regwriteW),
      .fwde      (fwdb_e),
      .fwdd      (forwardBD)
   );

   assign forwardAE = fwda_e;
   assign forwardBE = fwdb_e;

   // Load in E feeding either Decode operand: value not ready until after M.
   assign lwstall = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

   // Branch compares in Decode, so it needs results that bypass from M at the latest.
   assign brstall = branchD &&
                    ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                     (memtoregM && (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))));

   assign mem_pending = memreqM && !memackM;
   // A faulted pipeline stays frozen until reset.
   assign memstall    = (state == FAULT) ? 1'b1 : mem_pending;

   assign stallF = lwstall || brstall || memstall;
   assign stallD = stallF;
   assign stallE = memstall;
   assign stallM = memstall;
   assign flushW = memstall;
   // With M frozen, E must hold its instruction rather than take a bubble.
   assign flushE = (lwstall || brstall) && !memstall;
   // A taken branch under stall is re-evaluated once Decode is free to advance.
   assign flushD = pcsrcD && !stallD;

   assign fault = (state == FAULT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         waitcnt  <= 8'd0;
         stallcnt <= 16'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_pending) begin
                  state   <= MEM_WAIT;
                  waitcnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (memackM) begin
                  state   <= RUN;
                  waitcnt <= 8'd0;
               end else if (waitcnt == MEM_TIMEOUT) begin
                  state <= FAULT;
               end else if (waitcnt != 8'hFF) begin
                  waitcnt <= waitcnt + 8'd1;
               end
            end
            default: begin
               state <= FAULT;
            end
         endcase

         if (stallcnt_clr)
            stallcnt <= 16'd0;
         else if (stallF && (stallcnt != 16'hFFFF))
            stallcnt <= stallcnt + 16'd1;
      end
   end

endmodule
